conv3x3_sequencer: RTL and testbench
====================================

Name: conv3x3_sequencer

Overview:
- Sequences one 3x3 convolution pass (stride 1, no padding) over an IMG_H x IMG_W 8-bit ifmap held in external synchronous memory.
- Loads and holds 9 filter weights, gathers each 3x3 window, and drives the 9-PE 3x3 kernel datapath (72-bit ifmap/filter buses, 144-bit psum bus).
- Reduces the 9 products to one 20-bit result and streams results out with valid/ready, in raster order.

Parameters:
IMG_W, 8, ifmap width in pixels (>=3)
IMG_H, 8, ifmap height in pixels (>=3)
ADDR_W, 16, ifmap memory address width

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin pass; sampled only in IDLE
load_wt  in  1  sampled with start: 1 = load new weights first, 0 = reuse held weights
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of pass
wt_valid  in  1  weight byte valid
wt_data  in  8  weight byte, tap order 0..8 = (ky,kx) raster
wt_ready  out  1  high only in LOAD_W
mem_re  out  1  ifmap read strobe
mem_addr  out  ADDR_W  ifmap read address = row*IMG_W+col
mem_rdata  in  8  read data, valid exactly 1 cycle after mem_re
kern_ifmap  out  72  window to datapath; tap k at bits [71-8k -: 8]
kern_filter  out  72  weights to datapath; same tap mapping
kern_psum  in  144  datapath products; tap k at [143-16k -: 16], combinational from kern_* buses
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  20  unsigned sum of 9 psums
out_row  out  8  output row index r
out_col  out  8  output column index c

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, wt_ready, mem_re, out_valid = 0; mem_addr, out_data, out_row, out_col, kern_ifmap, kern_filter = 0; held weights cleared; r = c = 0.
- States: IDLE, LOAD_W, FETCH, WAIT, SUM, OUT, DONE.
- IDLE: start=1 -> LOAD_W if load_wt=1 else FETCH; r = c = 0. start outside IDLE ignored.
- LOAD_W: wt_ready=1; each cycle with wt_valid=1 stores wt_data into tap slot n, n++. After 9th byte -> FETCH. wt_valid gaps allowed, no timeout.
- FETCH: 9 cycles, cycle k (0..8) drives mem_re=1, mem_addr=(r+k/3)*IMG_W + c+k%3. mem_rdata captured into window slot k the following cycle. After k=8 -> WAIT.
- WAIT: 1 cycle, mem_re=0, captures tap 8 -> SUM.
- SUM: 1 cycle; out_data <= sum of the 9 unsigned 16-bit psums, zero-extended to 20 bits (max 9*65025=585225, no overflow); out_row/out_col <= r/c; out_valid <= 1 -> OUT.
- OUT: out_valid held with out_data/out_row/out_col stable until out_ready=1. On that handshake cycle out_valid <= 0, then: if c<IMG_W-3: c++ -> FETCH; else if r<IMG_H-3: c=0, r++ -> FETCH; else -> DONE.
- DONE: done=1 for 1 cycle -> IDLE (busy=0 next cycle).
- Throughput: 12 cycles per output with out_ready tied high; first out_valid 11 cycles after first FETCH cycle.
- kern_filter reflects held weights continuously. kern_ifmap reflects window register continuously; only sampled in SUM.
- Weights persist across passes until reset or next load.
- Reset mid-pass: immediate abort, all state as reset; no done pulse.

Test Plan:
- All 64 ifmap bytes = 1, load weights all 1, 8x8 -> 36 outputs, each out_data=9, (row,col) (0,0)..(5,5) raster, then one done pulse.
- ifmap[a]=a (a=0..63), weights tap4=1 else 0 -> out_data = (r+1)*8+(c+1); first=9, last (5,5)=54; mem_addr sequence for (0,0) = 0,1,2,8,9,10,16,17,18.
- ifmap all 255, weights all 255 -> out_data=585225 every output; no wrap.
- out_ready held low 5 cycles on output (2,3) -> out_valid/out_data stable throughout, no mem_re during stall, next FETCH starts cycle after handshake.
- Second pass with load_wt=0 after first scenario -> wt_ready never asserts, same results as first pass; start pulsed while busy -> ignored, output count still 36.
- rst_n low during FETCH of output (1,1) -> all outputs zero immediately, busy=0, no done; new start with load_wt=0 -> all results 0 (weights cleared).

Source files
------------

// File: rtl/conv3x3_sequencer.sv
// conv3x3_sequencer
//   Sequences one stride-1, unpadded 3x3 convolution pass over an
//   IMG_H x IMG_W 8-bit ifmap held in synchronous external memory.
//   Holds 9 filter weights, gathers each 3x3 window, presents it to an
//   external 9-PE datapath and reduces the 9 products into a 20-bit result
//   streamed out in raster order with valid/ready.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start, load_wt        begin pass (IDLE only); load weights first if load_wt
//   busy, done            busy outside IDLE; one-cycle done pulse at end of pass
//   wt_valid/wt_data/wt_ready   weight byte stream, taps 0..8 in (ky,kx) raster
//   mem_re/mem_addr/mem_rdata   ifmap read port, data returns one cycle after mem_re
//   kern_ifmap/kern_filter      window and weights, tap k at [71-8k -: 8]
//   kern_psum                   products from datapath, tap k at [143-16k -: 16]
//   out_valid/out_ready/out_data/out_row/out_col   result stream
module conv3x3_sequencer #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_wt,
  output logic              busy,
  output logic              done,
  input  logic              wt_valid,
  input  logic [7:0]        wt_data,
  output logic              wt_ready,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [71:0]       kern_ifmap,
  output logic [71:0]       kern_filter,
  input  logic [143:0]      kern_psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [19:0]       out_data,
  output logic [7:0]        out_row,
  output logic [7:0]        out_col
);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, FETCH, WAIT, SUM, OUT, DONE
  } state_t;

  state_t      state, next_state;
  logic [3:0]  k_cnt;      // fetch tap index 0..8
  logic [3:0]  n_cnt;      // weight load index 0..8
  logic        cap_en;     // read issued last cycle, capture mem_rdata now
  logic [3:0]  cap_idx;
  logic [7:0]  weights [9];
  logic [7:0]  window  [9];
  logic [7:0]  r, c;
  logic        last_col, last_row;
  logic [1:0]  kr, kc;
  logic [19:0] psum_sum;

  assign last_col = (c >= 8'(IMG_W - 3));
  assign last_row = (r >= 8'(IMG_H - 3));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (start) next_state = load_wt ? LOAD_W : FETCH;
      LOAD_W: if (wt_valid && n_cnt == 4'd8) next_state = FETCH;
      FETCH:  if (k_cnt == 4'd8) next_state = WAIT;
      WAIT:   next_state = SUM;
      SUM:    next_state = OUT;
      OUT:    if (out_ready) next_state = (last_col && last_row) ? DONE : FETCH;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Window-relative row/column of the tap being fetched
  always_comb begin
    kr = (k_cnt >= 4'd6) ? 2'd2 : (k_cnt >= 4'd3) ? 2'd1 : 2'd0;
    kc = 2'(k_cnt - 4'(kr) * 4'd3);
  end

  // Output logic
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    wt_ready  = (state == LOAD_W);
    mem_re    = (state == FETCH);
    out_valid = (state == OUT);
    mem_addr  = '0;
    if (state == FETCH)
      mem_addr = ADDR_W'((32'(r) + 32'(kr)) * 32'(IMG_W) + 32'(c) + 32'(kc));
    kern_ifmap  = '0;
    kern_filter = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      kern_ifmap[71-8*i -: 8]  = window[i];
      kern_filter[71-8*i -: 8] = weights[i];
    end
  end

  // Reduction of the 9 datapath products
  always_comb begin
    psum_sum = '0;
    for (int unsigned i = 0; i < 9; i++)
      psum_sum = psum_sum + 20'(kern_psum[143-16*i -: 16]);
  end

  // Counters, weight/window storage, result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_cnt    <= '0;
      n_cnt    <= '0;
      cap_en   <= 1'b0;
      cap_idx  <= '0;
      r        <= '0;
      c        <= '0;
      out_data <= '0;
      out_row  <= '0;
      out_col  <= '0;
      for (int unsigned i = 0; i < 9; i++) begin
        weights[i] <= '0;
        window[i]  <= '0;
      end
    end else begin
      // Read data lands one cycle after the strobe, so the capture
      // slot is pipelined alongside it (tap 8 lands during WAIT).
      cap_en  <= (state == FETCH);
      cap_idx <= k_cnt;
      if (cap_en) window[cap_idx] <= mem_rdata;

      unique case (state)
        IDLE: begin
          if (start) begin
            r     <= '0;
            c     <= '0;
            n_cnt <= '0;
            k_cnt <= '0;
          end
        end
        LOAD_W: begin
          if (wt_valid) begin
            weights[n_cnt] <= wt_data;
            n_cnt          <= n_cnt + 4'd1;
          end
        end
        FETCH: begin
          k_cnt <= (k_cnt == 4'd8) ? 4'd0 : k_cnt + 4'd1;
        end
        SUM: begin
          out_data <= psum_sum;
          out_row  <= r;
          out_col  <= c;
        end
        OUT: begin
          if (out_ready) begin
            k_cnt <= '0;
            if (!last_col) begin
              c <= c + 8'd1;
            end else if (!last_row) begin
              c <= '0;
              r <= r + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Testbench for conv3x3_sequencer: models the ifmap memory and the 9-PE
// multiply datapath, runs a table of full passes, a reset abort sequence,
// and a post-reset pass with held weights expected cleared.
module tb_conv3x3_sequencer;
  localparam int W = 8;
  localparam int H = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, load_wt, wt_valid, out_ready;
  logic [7:0]   wt_data, mem_rdata;
  logic         busy, done, wt_ready, mem_re, out_valid;
  logic [15:0]  mem_addr;
  logic [71:0]  kern_ifmap, kern_filter;
  logic [143:0] kern_psum;
  logic [19:0]  out_data;
  logic [7:0]   out_row, out_col;

  conv3x3_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_wt(load_wt),
    .busy(busy), .done(done), .wt_valid(wt_valid), .wt_data(wt_data),
    .wt_ready(wt_ready), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .kern_ifmap(kern_ifmap), .kern_filter(kern_filter),
    .kern_psum(kern_psum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;

  logic [7:0] img   [64];
  logic [7:0] cur_w [9];   // weights fed on the stream this pass
  logic [7:0] mw    [9];   // weights the DUT is expected to hold

  // Synchronous memory: one-cycle read latency
  always @(posedge clk) if (mem_re) mem_rdata <= img[mem_addr[5:0]];

  // External 9-PE datapath
  always_comb begin
    kern_psum = '0;
    for (int k = 0; k < 9; k++)
      kern_psum[143-16*k -: 16] = 16'(kern_ifmap[71-8*k -: 8]) * 16'(kern_filter[71-8*k -: 8]);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int model(int r, int c);
    int s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        s += int'(img[(r+ky)*W + c + kx]) * int'(mw[ky*3+kx]);
    return s;
  endfunction

  typedef struct {
    bit ld;
    int img_sel;    // 0 all ones, 1 ramp a, 2 all 255
    int wt_sel;     // 0 all ones, 1 centre tap only, 2 all 255
    bit stall;      // hold out_ready low 5 cycles on output (2,3)
    bit spam;       // pulse start while busy
    bit addr_chk;   // check address sequence and latency
    int exp_first;
    int exp_last;
  } vec_t;

  vec_t vecs [4];

  int  n_out, n_done, first_val, last_val;
  bit  wt_ready_seen;
  int  exp_addr [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

  task automatic setup(input int img_sel, input int wt_sel, input bit ld);
    for (int a = 0; a < 64; a++)
      img[a] = (img_sel == 0) ? 8'd1 : (img_sel == 1) ? 8'(a) : 8'd255;
    for (int k = 0; k < 9; k++)
      cur_w[k] = (wt_sel == 0) ? 8'd1 : (wt_sel == 1) ? ((k == 4) ? 8'd1 : 8'd0) : 8'd255;
    if (ld) for (int k = 0; k < 9; k++) mw[k] = cur_w[k];
  endtask

  // Runs one pass; abort_n >= 0 asserts reset during the fetch that
  // follows output number abort_n.
  task automatic run_pass(input bit ld, input bit stall_en, input bit spam,
                          input bit addr_chk, input int abort_n);
    int cyc = 0, widx = 0, stall = 0, first_fetch = -1, prev_out = 0;
    int addr_n = 0, abort_cnt = 0;
    bit gap_done = 0, after_hs = 0, finished = 0;
    logic [19:0] hold_data = '0;
    n_out = 0; n_done = 0; first_val = -1; last_val = -1; wt_ready_seen = 0;

    @(posedge clk); #1;
    start = 1'b1; load_wt = ld;
    @(posedge clk); #1;
    start = 1'b0; load_wt = 1'b0;

    while (cyc < 3000 && !finished) begin
      if (wt_ready) wt_ready_seen = 1;
      if (mem_re && first_fetch < 0) first_fetch = cyc;
      if (addr_chk && mem_re && addr_n < 9) begin
        chk("addr_seq", 32'(mem_addr), exp_addr[addr_n]);
        addr_n++;
      end
      if (after_hs) begin
        chk("fetch_after_handshake", {15'd0, mem_re, mem_addr}, {15'd0, 1'b1, 16'd20});
        after_hs = 0;
      end

      if (abort_n >= 0 && n_out == abort_n) begin
        abort_cnt++;
        if (abort_cnt == 3) begin
          chk("in_fetch_before_reset", 32'(mem_re), 1);
          rst_n = 1'b0;
          #1;
          chk("abort_ctrl", {27'd0, busy, done, wt_ready, mem_re, out_valid}, 0);
          chk("abort_addr", 32'(mem_addr), 0);
          chk("abort_data", 32'(out_data), 0);
          chk("abort_rowcol", {16'd0, out_row, out_col}, 0);
          chk("abort_kern_zero", 32'(kern_ifmap == '0 && kern_filter == '0), 1);
          for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
          end
          chk("abort_no_done", n_done, 0);
          rst_n = 1'b1;
          return;
        end
      end

      if (done) begin
        n_done++;
        @(posedge clk); #1;
        chk("idle_after_done", {30'd0, busy, done}, 0);
        finished = 1;
      end else begin
        wt_valid = 1'b0;
        if (wt_ready && widx < 9) begin
          if (widx == 4 && !gap_done) gap_done = 1;
          else begin
            wt_valid = 1'b1;
            wt_data  = cur_w[widx];
            widx++;
          end
        end

        out_ready = 1'b1;
        if (out_valid) begin
          if (stall_en && out_row == 8'd2 && out_col == 8'd3 && stall < 5) begin
            if (stall == 0) hold_data = out_data;
            else chk("stall_stable", {3'd0, out_valid, out_data, out_row}, {3'd0, 1'b1, hold_data, 8'd2});
            chk("stall_no_mem_re", {31'd0, mem_re}, 0);
            out_ready = 1'b0;
            stall++;
          end else begin
            chk("out_data", 32'(out_data), model(n_out / 6, n_out % 6));
            chk("out_rowcol", {16'd0, out_row, out_col}, {16'd0, 8'(n_out / 6), 8'(n_out % 6)});
            if (addr_chk) begin
              if (n_out == 0) chk("first_latency", cyc - first_fetch, 11);
              else            chk("period", cyc - prev_out, 12);
            end
            if (stall_en && out_row == 8'd2 && out_col == 8'd3) after_hs = 1;
            if (n_out == 0) first_val = int'(out_data);
            last_val = int'(out_data);
            prev_out = cyc;
            n_out++;
          end
        end

        start   = (spam && cyc == 50);
        load_wt = (spam && cyc == 50);
        @(posedge clk); #1;
        cyc++;
      end
    end
    wt_valid = 1'b0;
    start = 1'b0; load_wt = 1'b0;
    chk("pass_finished", {31'd0, finished}, 1);
    chk("out_count", n_out, 36);
    chk("done_count", n_done, 1);
    if (!ld) chk("wt_ready_unused", {31'd0, wt_ready_seen}, 0);
  endtask

  initial begin
    vecs[0] = '{ld: 1, img_sel: 0, wt_sel: 0, stall: 0, spam: 0, addr_chk: 0, exp_first: 9,      exp_last: 9};
    vecs[1] = '{ld: 0, img_sel: 0, wt_sel: 0, stall: 0, spam: 1, addr_chk: 0, exp_first: 9,      exp_last: 9};
    vecs[2] = '{ld: 1, img_sel: 1, wt_sel: 1, stall: 0, spam: 0, addr_chk: 1, exp_first: 9,      exp_last: 54};
    vecs[3] = '{ld: 1, img_sel: 2, wt_sel: 2, stall: 1, spam: 0, addr_chk: 0, exp_first: 585225, exp_last: 585225};

    rst_n = 1'b0; start = 1'b0; load_wt = 1'b0; wt_valid = 1'b0;
    wt_data = '0; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) mw[k] = '0;
    #1;
    chk("reset_ctrl", {27'd0, busy, done, wt_ready, mem_re, out_valid}, 0);
    chk("reset_data", {out_data, 12'd0}, 0);
    chk("reset_kern_zero", 32'(kern_ifmap == '0 && kern_filter == '0 && mem_addr == '0), 1);
    #20;
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      setup(vecs[v].img_sel, vecs[v].wt_sel, vecs[v].ld);
      run_pass(vecs[v].ld, vecs[v].stall, vecs[v].spam, vecs[v].addr_chk, -1);
      chk("first_result", first_val, vecs[v].exp_first);
      chk("last_result", last_val, vecs[v].exp_last);
    end

    // Abort during fetch of output (1,1), which follows 7 completed outputs
    setup(1, 0, 1);
    run_pass(1'b1, 1'b0, 1'b0, 1'b0, 7);

    // Weights were cleared by reset: every result is zero
    for (int k = 0; k < 9; k++) mw[k] = '0;
    run_pass(1'b0, 1'b0, 1'b0, 1'b0, -1);
    chk("post_reset_first", first_val, 0);
    chk("post_reset_last", last_val, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
